// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port arbiter in front of a single synchronous microcode ROM.
// Ports A and B each raise a fetch request. One request is granted per cycle,
// with round-robin priority. The ROM read result is returned to the granting
// port two cycles after its ack.
//
// Ports
//    clk, reset          single clock, synchronous active-high reset
//    req_x, addr_x       fetch request and address (x = a, b)
//    ack_x               one-cycle pulse: request accepted
//    valid_x             one-cycle pulse: dout_x/daddr_x just updated
//    dout_x, daddr_x     last fetched word and its address
//    rom_en, rom_addr    ROM read strobe and address (registered)
//    rom_dout            ROM data, valid the cycle after the ROM sampled rom_en
module rom_arbiter #(
   parameter int AW        = 9,
   parameter int DW        = 32,
   parameter int PRIO_INIT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_a,
   input  logic [AW:1]   addr_a,
   output logic          ack_a,
   output logic          valid_a,
   output logic [DW:1]   dout_a,
   output logic [AW:1]   daddr_a,
   input  logic          req_b,
   input  logic [AW:1]   addr_b,
   output logic          ack_b,
   output logic          valid_b,
   output logic [DW:1]   dout_b,
   output logic [AW:1]   daddr_b,
   output logic          rom_en,
   output logic [AW:1]   rom_addr,
   input  logic [DW:1]   rom_dout
);

   localparam logic PRIO_RST = (PRIO_INIT != 0);

   // Grant stage
   logic          ack_a_q, ack_b_q, rom_en_q;
   logic [AW:1]   rom_addr_q, rom_addr_d;
   logic          prio_q, prio_d;       // 0 = A holds priority, 1 = B
   logic          grant_a_d, grant_b_d;
   logic          elig_a, elig_b;

   // ROM access stage: tracks which port owns the word the ROM is producing
   logic          s1_vld_q, s1_port_q;
   logic [AW:1]   s1_addr_q;

   // Return stage
   logic          valid_a_q, valid_b_q;
   logic [DW:1]   dout_a_q, dout_b_q;
   logic [AW:1]   daddr_a_q, daddr_b_q;

   // A port just acked is not eligible; this enforces the 2-cycle minimum
   // service interval and gives alternation under continuous requests.
   assign elig_a = req_a & ~ack_a_q;
   assign elig_b = req_b & ~ack_b_q;

   always_comb begin
      grant_a_d = 1'b0;
      grant_b_d = 1'b0;
      prio_d    = prio_q;
      if (elig_a && elig_b) begin
         grant_a_d = ~prio_q;
         grant_b_d = prio_q;
         prio_d    = ~prio_q;
      end else if (elig_a) begin
         grant_a_d = 1'b1;
         prio_d    = 1'b1;
      end else if (elig_b) begin
         grant_b_d = 1'b1;
         prio_d    = 1'b0;
      end
   end

   always_comb begin
      rom_addr_d = rom_addr_q;
      if (grant_a_d)
         rom_addr_d = addr_a;
      else if (grant_b_d)
         rom_addr_d = addr_b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         prio_q     <= PRIO_RST;
         s1_vld_q   <= 1'b0;
         s1_port_q  <= 1'b0;
         s1_addr_q  <= '0;
         valid_a_q  <= 1'b0;
         valid_b_q  <= 1'b0;
         dout_a_q   <= '0;
         dout_b_q   <= '0;
         daddr_a_q  <= '0;
         daddr_b_q  <= '0;
      end else begin
         ack_a_q    <= grant_a_d;
         ack_b_q    <= grant_b_d;
         rom_en_q   <= grant_a_d | grant_b_d;
         rom_addr_q <= rom_addr_d;
         prio_q     <= prio_d;

         // ROM samples rom_en/rom_addr on this edge; remember the owner.
         s1_vld_q   <= rom_en_q;
         s1_port_q  <= ack_b_q;
         s1_addr_q  <= rom_addr_q;

         valid_a_q  <= s1_vld_q & ~s1_port_q;
         valid_b_q  <= s1_vld_q & s1_port_q;
         if (s1_vld_q && !s1_port_q) begin
            dout_a_q  <= rom_dout;
            daddr_a_q <= s1_addr_q;
         end
         if (s1_vld_q && s1_port_q) begin
            dout_b_q  <= rom_dout;
            daddr_b_q <= s1_addr_q;
         end
      end
   end

   assign ack_a    = ack_a_q;
   assign ack_b    = ack_b_q;
   assign rom_en   = rom_en_q;
   assign rom_addr = rom_addr_q;
   assign valid_a  = valid_a_q;
   assign valid_b  = valid_b_q;
   assign dout_a   = dout_a_q;
   assign dout_b   = dout_b_q;
   assign daddr_a  = daddr_a_q;
   assign daddr_b  = daddr_b_q;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_a, req_b;
   logic [AW:1]   addr_a, addr_b;
   logic          ack_a, ack_b, valid_a, valid_b;
   logic [DW:1]   dout_a, dout_b;
   logic [AW:1]   daddr_a, daddr_b;
   logic          rom_en;
   logic [AW:1]   rom_addr;
   logic [DW:1]   rom_dout = '0;

   int checks = 0;
   int passes = 0;

   logic [AW:1] exp_a[$];
   logic [AW:1] exp_b[$];

   rom_arbiter #(.AW(AW), .DW(DW), .PRIO_INIT(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_a    (req_a),
      .addr_a   (addr_a),
      .ack_a    (ack_a),
      .valid_a  (valid_a),
      .dout_a   (dout_a),
      .daddr_a  (daddr_a),
      .req_b    (req_b),
      .addr_b   (addr_b),
      .ack_b    (ack_b),
      .valid_b  (valid_b),
      .dout_b   (dout_b),
      .daddr_b  (daddr_b),
      .rom_en   (rom_en),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [DW:1] rom_word(input logic [AW:1] a);
      if (a == 9'h005) return 32'hDEADBEEF;
      return {16'hC0DE, 7'h00, a};
   endfunction

   // Synchronous ROM model: data appears after the edge that sampled rom_en.
   always @(posedge clk)
      if (rom_en) rom_dout <= rom_word(rom_addr);

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_a = 1'b1; addr_a = 9'h005; req_b = 1'b0; addr_b = '0;
      tick();
      tick();
      checks++; if ({rom_en, ack_a, ack_b, valid_a, valid_b} !== 5'b0)
         $display("FAIL reset_ctrl: got %b want 00000", {rom_en, ack_a, ack_b, valid_a, valid_b}); else passes++;
      checks++; if ({rom_addr, daddr_a, daddr_b} !== '0)
         $display("FAIL reset_addr: got %h want 0", {rom_addr, daddr_a, daddr_b}); else passes++;
      checks++; if ({dout_a, dout_b} !== '0)
         $display("FAIL reset_dout: got %h want 0", {dout_a, dout_b}); else passes++;
      reset = 1'b0;
      tick();
      checks++; if (ack_a !== 1'b1)
         $display("FAIL reset_first_ack: got %b want 1", ack_a); else passes++;
      req_a = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req_a = 1'b1; addr_a = 9'h005;
      tick();
      checks++; if ({ack_a, ack_b, rom_en} !== 3'b101 || rom_addr !== 9'h005)
         $display("FAIL single_grant: got ack_a/ack_b/en=%b addr=%h want 101 005", {ack_a, ack_b, rom_en}, rom_addr); else passes++;
      req_a = 1'b0;
      tick();
      checks++; if ({ack_a, valid_a, rom_en} !== 3'b000)
         $display("FAIL single_e1: got %b want 000", {ack_a, valid_a, rom_en}); else passes++;
      tick();
      checks++; if (valid_a !== 1'b1 || dout_a !== 32'hDEADBEEF || daddr_a !== 9'h005)
         $display("FAIL single_valid: got v=%b d=%h a=%h want 1 deadbeef 005", valid_a, dout_a, daddr_a); else passes++;
      tick();
      checks++; if (valid_a !== 1'b0 || dout_a !== 32'hDEADBEEF)
         $display("FAIL single_hold: got v=%b d=%h want 0 deadbeef", valid_a, dout_a); else passes++;
   endtask

   task automatic test_both();
      do_reset();
      req_a = 1'b1; addr_a = 9'h010;
      req_b = 1'b1; addr_b = 9'h020;
      tick();
      checks++; if ({ack_a, ack_b} !== 2'b10 || rom_addr !== 9'h010)
         $display("FAIL both_e0: got acks=%b addr=%h want 10 010", {ack_a, ack_b}, rom_addr); else passes++;
      req_a = 1'b0;
      tick();
      checks++; if ({ack_a, ack_b} !== 2'b01 || rom_addr !== 9'h020)
         $display("FAIL both_e1: got acks=%b addr=%h want 01 020", {ack_a, ack_b}, rom_addr); else passes++;
      req_b = 1'b0;
      tick();
      checks++; if ({valid_a, valid_b} !== 2'b10 || dout_a !== 32'hC0DE0010 || daddr_a !== 9'h010)
         $display("FAIL both_valid_a: got v=%b d=%h a=%h want 10 c0de0010 010", {valid_a, valid_b}, dout_a, daddr_a); else passes++;
      tick();
      checks++; if ({valid_a, valid_b} !== 2'b01 || dout_b !== 32'hC0DE0020 || daddr_b !== 9'h020)
         $display("FAIL both_valid_b: got v=%b d=%h a=%h want 01 c0de0020 020", {valid_a, valid_b}, dout_b, daddr_b); else passes++;
   endtask

   task automatic test_back_to_back();
      int na = 0;
      int nb = 0;
      logic [AW:1] ea;
      logic [AW:1] eb;
      do_reset();
      exp_a.delete();
      exp_b.delete();
      req_a = 1'b1; addr_a = 9'h030;
      req_b = 1'b1; addr_b = 9'h040;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i < 10) begin
            checks++; if ({rom_en, ack_a, ack_b} !== {1'b1, (i % 2) == 0, (i % 2) == 1})
               $display("FAIL b2b_grant[%0d]: got en/acks=%b want %b", i, {rom_en, ack_a, ack_b}, {1'b1, (i % 2) == 0, (i % 2) == 1}); else passes++;
         end
         if (valid_a) begin
            na++;
            ea = (exp_a.size() != 0) ? exp_a.pop_front() : 9'h1FF;
            checks++; if (dout_a !== rom_word(ea) || daddr_a !== ea)
               $display("FAIL b2b_data_a: got %h@%h want %h@%h", dout_a, daddr_a, rom_word(ea), ea); else passes++;
         end
         if (valid_b) begin
            nb++;
            eb = (exp_b.size() != 0) ? exp_b.pop_front() : 9'h1FF;
            checks++; if (dout_b !== rom_word(eb) || daddr_b !== eb)
               $display("FAIL b2b_data_b: got %h@%h want %h@%h", dout_b, daddr_b, rom_word(eb), eb); else passes++;
         end
         if (ack_a) begin exp_a.push_back(addr_a); addr_a = addr_a + 9'd1; end
         if (ack_b) begin exp_b.push_back(addr_b); addr_b = addr_b + 9'd1; end
         if (i == 9) begin req_a = 1'b0; req_b = 1'b0; end
      end
      checks++; if (na !== 5 || nb !== 5)
         $display("FAIL b2b_count: got a=%0d b=%0d want 5 5", na, nb); else passes++;
   endtask

   task automatic test_single_requester();
      int nb = 0;
      do_reset();
      req_b = 1'b1; addr_b = 9'h050;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i < 6) begin
            checks++; if ({ack_a, ack_b} !== {1'b0, (i % 2) == 0})
               $display("FAIL solo_ack[%0d]: got %b want %b", i, {ack_a, ack_b}, {1'b0, (i % 2) == 0}); else passes++;
         end
         if (valid_b) begin
            nb++;
            checks++; if (dout_b !== 32'hC0DE0050)
               $display("FAIL solo_data: got %h want c0de0050", dout_b); else passes++;
         end
         if (i == 5) req_b = 1'b0;
      end
      checks++; if (nb !== 3)
         $display("FAIL solo_count: got %0d want 3", nb); else passes++;
   endtask

   task automatic test_reset_in_flight();
      do_reset();
      req_a = 1'b1; addr_a = 9'h060;
      tick();
      checks++; if (ack_a !== 1'b1)
         $display("FAIL flight_ack: got %b want 1", ack_a); else passes++;
      req_a = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if ({rom_en, ack_a, ack_b, valid_a, valid_b} !== 5'b0 || rom_addr !== '0)
         $display("FAIL flight_reset: got %b addr=%h want 00000 000", {rom_en, ack_a, ack_b, valid_a, valid_b}, rom_addr); else passes++;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (valid_a !== 1'b0 || dout_a !== '0 || daddr_a !== '0)
            $display("FAIL flight_discard[%0d]: got v=%b d=%h want 0 0", i, valid_a, dout_a); else passes++;
      end
      req_a = 1'b1; addr_a = 9'h061;
      req_b = 1'b1; addr_b = 9'h062;
      tick();
      checks++; if ({ack_a, ack_b} !== 2'b10)
         $display("FAIL flight_prio: got %b want 10", {ack_a, ack_b}); else passes++;
      req_a = 1'b0; req_b = 1'b0;
   endtask

   task automatic test_withdraw();
      do_reset();
      req_a = 1'b1; addr_a = 9'h005;
      tick();
      req_a = 1'b0;
      tick();
      tick();
      checks++; if (valid_a !== 1'b1 || dout_a !== 32'hDEADBEEF)
         $display("FAIL wd_setup: got v=%b d=%h want 1 deadbeef", valid_a, dout_a); else passes++;
      // priority now with B; a one-cycle A request loses and is withdrawn
      req_a = 1'b1; addr_a = 9'h070;
      req_b = 1'b1; addr_b = 9'h080;
      tick();
      checks++; if ({ack_a, ack_b} !== 2'b01)
         $display("FAIL wd_grant: got %b want 01", {ack_a, ack_b}); else passes++;
      req_a = 1'b0; req_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (ack_a !== 1'b0 || valid_a !== 1'b0 || dout_a !== 32'hDEADBEEF)
            $display("FAIL wd_quiet[%0d]: got ack=%b v=%b d=%h want 0 0 deadbeef", i, ack_a, valid_a, dout_a); else passes++;
      end
   endtask

   initial begin
      reset = 1'b1;
      req_a = 1'b0; req_b = 1'b0;
      addr_a = '0;  addr_b = '0;
      test_reset();
      test_single();
      test_both();
      test_back_to_back();
      test_single_requester();
      test_reset_in_flight();
      test_withdraw();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
